croc_boot_ctrl: RTL and testbench

CROC_BOOT_CTRL -- requirements
Module: croc_boot_ctrl

---
 rtl/croc_pkg.sv | 22 ++
 rtl/croc_debounce.sv | 51 +++++
 rtl/croc_boot_ctrl.sv | 151 +++++++++++++++
 tb/tb_croc_boot_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/croc_pkg.sv
// Shared types and helpers for the Croc boot controller.
package croc_pkg;

  // Boot sequencer states; the numeric encoding is exported on state_o.
  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    WAIT_FETCH = 2'd1,
    RUNNING    = 2'd2,
    DONE       = 2'd3
  } boot_state_e;

  // The SoC is allowed to fetch instructions in RUNNING and DONE only.
  function automatic logic state_fetches(input boot_state_e s);
    return (s == RUNNING) || (s == DONE);
  endfunction

  // The SoC is held in reset only while the sequencer is in RESET_HOLD.
  function automatic logic state_releases_rst(input boot_state_e s);
    return (s != RESET_HOLD);
  endfunction

endpackage

// File: rtl/croc_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw
// board input. The debounced value only follows the synced sample after it
// has differed from the current debounced value for DebounceCycles cycles.
module croc_debounce #(
  parameter int unsigned DebounceCycles = 65536
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic deb_o
);

  localparam int unsigned CntW = $clog2(DebounceCycles) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic            sync1_q, sync2_q;
  logic            deb_d, deb_q;
  logic [CntW-1:0] cnt_d, cnt_q;

  // Stable-count debounce: restart on agreement, accept after CntMax+1 differing cycles.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Synchronizer chain plus debounce state, all cleared by the synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/croc_boot_ctrl.sv
// Board-level boot sequencer for the Croc SoC: debounces the user reset and
// fetch-enable switches, holds the SoC in reset for a fixed time, gates
// instruction fetch and drives a state-dependent status LED.
module croc_boot_ctrl
  import croc_pkg::*;
#(
  parameter int unsigned RstHoldCycles  = 1024,
  parameter int unsigned DebounceCycles = 65536,
  parameter int unsigned HeartbeatDiv   = 1000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sw_reset_i,
  input  logic       sw_fetch_en_i,
  input  logic       soc_status_i,
  output logic       soc_rst_no,
  output logic       soc_fetch_en_o,
  output logic [1:0] state_o,
  output logic       led_o
);

  localparam int unsigned HoldW  = $clog2(RstHoldCycles - 1) + 1;
  localparam int unsigned BlinkW = $clog2(HeartbeatDiv - 1) + 1;

  localparam logic [HoldW-1:0]  HoldMax      = HoldW'(RstHoldCycles - 1);
  localparam logic [BlinkW-1:0] BlinkMaxWait = BlinkW'(HeartbeatDiv - 1);
  localparam logic [BlinkW-1:0] BlinkMaxDone = BlinkW'(HeartbeatDiv / 2 - 1);

  logic rst_deb;
  logic fetch_deb;

  boot_state_e       state_d, state_q;
  logic [HoldW-1:0]  hold_d, hold_q;
  logic [BlinkW-1:0] blink_d, blink_q;
  logic              led_d, led_q;
  logic              soc_rst_n_d, soc_rst_n_q;
  logic              fetch_en_d, fetch_en_q;

  croc_debounce #(
    .DebounceCycles(DebounceCycles)
  ) u_deb_reset (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .raw_i(sw_reset_i),
    .deb_o(rst_deb)
  );

  croc_debounce #(
    .DebounceCycles(DebounceCycles)
  ) u_deb_fetch (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .raw_i(sw_fetch_en_i),
    .deb_o(fetch_deb)
  );

  // Next-state logic; a debounced user reset overrides every other event.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RESET_HOLD: if (hold_q == HoldMax) state_d = WAIT_FETCH;
      WAIT_FETCH: if (fetch_deb)         state_d = RUNNING;
      RUNNING:    if (soc_status_i)      state_d = DONE;
      DONE:       state_d = DONE;
      default:    state_d = RESET_HOLD;
    endcase
    if (rst_deb) begin
      state_d = RESET_HOLD;
    end
  end

  // Hold counter: only counts while settled in RESET_HOLD with the button released.
  always_comb begin
    hold_d = '0;
    if ((state_q == RESET_HOLD) && (state_d == RESET_HOLD) && !rst_deb) begin
      hold_d = (hold_q == HoldMax) ? hold_q : hold_q + HoldW'(1);
    end
  end

  // Heartbeat LED: restarts on every state change, blink rate depends on state.
  always_comb begin
    blink_d = blink_q;
    led_d   = led_q;
    if (state_d != state_q) begin
      blink_d = '0;
      led_d   = (state_d == RUNNING);
    end else begin
      unique case (state_q)
        RESET_HOLD: begin
          blink_d = '0;
          led_d   = 1'b0;
        end
        WAIT_FETCH: begin
          if (blink_q == BlinkMaxWait) begin
            blink_d = '0;
            led_d   = ~led_q;
          end else begin
            blink_d = blink_q + BlinkW'(1);
          end
        end
        RUNNING: begin
          blink_d = '0;
          led_d   = 1'b1;
        end
        DONE: begin
          if (blink_q == BlinkMaxDone) begin
            blink_d = '0;
            led_d   = ~led_q;
          end else begin
            blink_d = blink_q + BlinkW'(1);
          end
        end
        default: begin
          blink_d = '0;
          led_d   = 1'b0;
        end
      endcase
    end
  end

  // SoC control outputs decode the next state so they switch together with state_o.
  always_comb begin
    soc_rst_n_d = state_releases_rst(state_d);
    fetch_en_d  = state_fetches(state_d);
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RESET_HOLD;
      hold_q      <= '0;
      blink_q     <= '0;
      led_q       <= 1'b0;
      soc_rst_n_q <= 1'b0;
      fetch_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      blink_q     <= blink_d;
      led_q       <= led_d;
      soc_rst_n_q <= soc_rst_n_d;
      fetch_en_q  <= fetch_en_d;
    end
  end

  assign state_o        = state_q;
  assign soc_rst_no     = soc_rst_n_q;
  assign soc_fetch_en_o = fetch_en_q;
  assign led_o          = led_q;

endmodule

// File: tb/tb_croc_boot_ctrl.sv
// Directed bench for croc_boot_ctrl with small parameters (hold 8, debounce 4,
// heartbeat 6). Expected values are hand-derived cycle counts from the raw
// switch edges and reset release.
module tb_croc_boot_ctrl;

  logic       clk;
  logic       rst_i;
  logic       sw_reset_i;
  logic       sw_fetch_en_i;
  logic       soc_status_i;
  logic       soc_rst_no;
  logic       soc_fetch_en_o;
  logic [1:0] state_o;
  logic       led_o;

  int checks   = 0;
  int failures = 0;

  croc_boot_ctrl #(
    .RstHoldCycles (8),
    .DebounceCycles(4),
    .HeartbeatDiv  (6)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .sw_reset_i    (sw_reset_i),
    .sw_fetch_en_i (sw_fetch_en_i),
    .soc_status_i  (soc_status_i),
    .soc_rst_no    (soc_rst_no),
    .soc_fetch_en_o(soc_fetch_en_o),
    .state_o       (state_o),
    .led_o         (led_o)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; inputs and checks happen 1 unit after the edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] observed,
                             input logic [1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [1:0] st, input logic rn,
                          input logic fe);
    checkOutput({tag, "_state"}, state_o, st);
    checkOutput({tag, "_rst_n"}, {1'b0, soc_rst_no}, {1'b0, rn});
    checkOutput({tag, "_fetch"}, {1'b0, soc_fetch_en_o}, {1'b0, fe});
  endtask

  initial begin
    rst_i         = 1'b1;
    sw_reset_i    = 1'b0;
    sw_fetch_en_i = 1'b0;
    soc_status_i  = 1'b0;
    #1;

    // Reset held for three edges.
    applyStimulus(3);
    checkAll("reset", 2'd0, 1'b0, 1'b0);
    checkOutput("reset_led", {1'b0, led_o}, 2'd0);
    rst_i = 1'b0;

    // Hold sequence: still in reset 7 edges after release, released at 8.
    applyStimulus(7);
    checkAll("hold7", 2'd0, 1'b0, 1'b0);
    applyStimulus(1);
    checkAll("hold8", 2'd1, 1'b1, 1'b0);
    checkOutput("wait_led_entry", {1'b0, led_o}, 2'd0);

    // Heartbeat in WAIT_FETCH: toggles every 6 cycles.
    applyStimulus(5);
    checkOutput("wait_led_5", {1'b0, led_o}, 2'd0);
    applyStimulus(1);
    checkOutput("wait_led_6", {1'b0, led_o}, 2'd1);
    applyStimulus(5);
    checkOutput("wait_led_11", {1'b0, led_o}, 2'd1);
    applyStimulus(1);
    checkOutput("wait_led_12", {1'b0, led_o}, 2'd0);

    // Three-cycle bounce on fetch enable must be rejected.
    sw_fetch_en_i = 1'b1;
    applyStimulus(3);
    sw_fetch_en_i = 1'b0;
    applyStimulus(6);
    checkAll("bounce", 2'd1, 1'b1, 1'b0);

    // Stable fetch enable: RUNNING exactly 7 edges after the raw edge.
    sw_fetch_en_i = 1'b1;
    applyStimulus(6);
    checkAll("fetch6", 2'd1, 1'b1, 1'b0);
    applyStimulus(1);
    checkAll("fetch7", 2'd2, 1'b1, 1'b1);
    checkOutput("run_led", {1'b0, led_o}, 2'd1);

    // Completion pulse moves to DONE next edge.
    soc_status_i = 1'b1;
    applyStimulus(1);
    soc_status_i = 1'b0;
    checkAll("done", 2'd3, 1'b1, 1'b1);
    checkOutput("done_led_entry", {1'b0, led_o}, 2'd0);

    // DONE heartbeat toggles every 3 cycles.
    applyStimulus(2);
    checkOutput("done_led_2", {1'b0, led_o}, 2'd0);
    applyStimulus(1);
    checkOutput("done_led_3", {1'b0, led_o}, 2'd1);
    applyStimulus(3);
    checkOutput("done_led_6", {1'b0, led_o}, 2'd0);

    // Releasing fetch enable in DONE has no effect; then re-engage it.
    sw_fetch_en_i = 1'b0;
    applyStimulus(10);
    checkAll("fetch_release", 2'd3, 1'b1, 1'b1);
    sw_fetch_en_i = 1'b1;
    applyStimulus(8);
    checkAll("fetch_reengage", 2'd3, 1'b1, 1'b1);

    // User reset held for 10 edges: RESET_HOLD at edge 7.
    sw_reset_i = 1'b1;
    applyStimulus(6);
    checkAll("ureset6", 2'd3, 1'b1, 1'b1);
    applyStimulus(1);
    checkAll("ureset7", 2'd0, 1'b0, 1'b0);
    checkOutput("ureset_led", {1'b0, led_o}, 2'd0);
    applyStimulus(3);
    sw_reset_i = 1'b0;

    // Debounced reset falls at edge 16, SoC released at 24, RUNNING at 25.
    applyStimulus(13);
    checkAll("ureset23", 2'd0, 1'b0, 1'b0);
    applyStimulus(1);
    checkAll("ureset24", 2'd1, 1'b1, 1'b0);
    applyStimulus(1);
    checkAll("ureset25", 2'd2, 1'b1, 1'b1);

    // Debounced reset and soc_status together in RUNNING: reset wins.
    sw_reset_i = 1'b1;
    applyStimulus(6);
    checkAll("prio_pre", 2'd2, 1'b1, 1'b1);
    soc_status_i = 1'b1;
    applyStimulus(1);
    soc_status_i = 1'b0;
    sw_reset_i   = 1'b0;
    checkAll("prio", 2'd0, 1'b0, 1'b0);

    // Recovery with fetch enable held: back to RUNNING after hold.
    applyStimulus(15);
    checkAll("prio_recover", 2'd2, 1'b1, 1'b1);

    // rst_i mid-operation overrides and restarts the full hold sequence.
    rst_i = 1'b1;
    applyStimulus(1);
    checkAll("midrst", 2'd0, 1'b0, 1'b0);
    checkOutput("midrst_led", {1'b0, led_o}, 2'd0);
    rst_i = 1'b0;
    applyStimulus(7);
    checkAll("midrst7", 2'd0, 1'b0, 1'b0);
    applyStimulus(1);
    checkAll("midrst8", 2'd1, 1'b1, 1'b0);
    applyStimulus(1);
    checkAll("midrst9", 2'd2, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
